dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbitrates the single-port data RAM between two requesters: the multi-cycle CPU (port 0) and a program/data loader or debug port (port 1). A three-state FSM sequences each transaction into one RAM access cycle plus one response cycle. Fair round-robin arbitration applies when both ports request. The block sits between the CPU datapath's memory-address/store-data registers and the data RAM, and replaces the direct CPU-to-RAM connection.

## Interface
- DATA_BUS_WIDTH, 16, data word width
- ADDR_WIDTH, 16, RAM address width
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low forces reset state immediately
- req[1:0]  in  2  per-port request, level; held until the port's done
- rnw[1:0]  in  2  per-port 1 = read, 0 = write
- addr0, addr1  in  ADDR_WIDTH  per-port address
- wdata0, wdata1  in  DATA_BUS_WIDTH  per-port write data
- grant[1:0]  out  2  one-cycle pulse: port's request accepted, inputs captured
- done[1:0]  out  2  one-cycle pulse: transaction complete, rdata valid for reads
- rdata0, rdata1  out  DATA_BUS_WIDTH  per-port read data register, holds until that port's next read completes
- mem_cs  out  1  RAM chip select
- mem_read_not_write  out  1  RAM direction
- mem_address  out  ADDR_WIDTH  RAM address
- mem_write_data  out  DATA_BUS_WIDTH  RAM write data
- mem_read_data  in  DATA_BUS_WIDTH  RAM read data, valid the cycle after the access cycle

## Operation
- States:
  - IDLE: no transaction active.
  - ACCESS: mem_cs=1; mem_address, mem_write_data and mem_read_not_write driven from the captured registers.
  - RESP: mem_cs=0; read data presented by the RAM.
- IDLE → ACCESS when any req bit is set.
  - The winner's rnw, addr and wdata are registered.
  - The winner's grant pulses in the IDLE cycle of the decision.
- ACCESS → RESP unconditionally.
- RESP behaviour:
  - Reads: the owner's rdata is loaded from mem_read_data at the end of RESP.
  - done[owner] is registered high for the next cycle.
- RESP exits:
  - RESP → ACCESS if any req is set. Arbitration and grant happen in RESP, excluding the current owner's req bit for this one cycle so that a level req which has not yet dropped is not double-served.
  - Otherwise RESP → IDLE.
- Arbitration:
  - Round-robin via a last_owner bit.
  - If both ports request, the port that is not last_owner wins.
  - A single requester always wins.
  - last_owner updates on each grant.
- Writes: RAM commits at the rising edge ending ACCESS. done still pulses after RESP so both ports see uniform timing.
- Idle outputs:
  - mem_cs=0.
  - mem_read_not_write=1 (safe read) whenever the state is not ACCESS.
  - mem_address and mem_write_data hold their last values.
- Requester contract:
  - The port holds req, rnw, addr and wdata stable from assertion until grant.
  - req is dropped in the cycle done is seen, unless a new transaction is wanted.
  - req still high two cycles after done is treated as a new request.

## Timing
- Reset values: state=IDLE, grant=0, done=0, rdata0=rdata1=0, mem_cs=0, mem_read_not_write=1, mem_address=0, mem_write_data=0, last_owner=1 (port 0 wins the first tie).
- Latency:
  - req sampled high in IDLE at cycle T (grant at T).
  - ACCESS at T+1, RESP at T+2.
  - done and valid rdata at T+3.
- Throughput: one transaction per 2 cycles under continuous demand. ACCESS and RESP alternate with no IDLE gap.
- Simultaneous events:
  - Both req rise in the same cycle: one grant only, per round-robin.
  - The loser stays pending and is granted in the RESP of the winner.
- Reset asserted mid-transaction:
  - Asynchronous return to IDLE, mem_cs drops immediately, no done is issued.
  - A write in ACCESS may or may not commit; software re-issues after reset.
- Address and data are passed through at full width; there is no arithmetic and no wrap handling.

## Structure
- State encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and port IDs (PORT_CPU=0, PORT_LOAD=1) go in the shared params.v include.
- Sub-module rr_arbiter2: combinational two-way round-robin pick from req, the mask and last_owner; outputs winner and valid.
- FSM, capture registers and rdata registers live in dmem_arbiter itself.

## Test plan
- Port 0 writes 16'hBEEF to 16'h0010, then reads 16'h0010 → grant at T, mem_cs at T+1 with mem_read_not_write=0, done0 at T+3. The read's done0 arrives with rdata0=16'hBEEF.
- Both ports request reads at the same cycle after reset → port 0 granted first, port 1 granted in port 0's RESP. done0 and done1 are 2 cycles apart and no IDLE gap appears.
- Both ports hold req continuously for 8 transactions → grants alternate 0,1,0,1…, each port completes exactly 4 transactions, mem_cs duty cycle is 50%.
- Port 1 reads while port 0 idles and port 1 holds req one extra cycle after done → exactly one extra transaction is started, not two. rdata0 is unchanged.
- reset driven low during ACCESS of a port 1 write → outputs return to reset values asynchronously and no done1 pulse appears. After release, a port 0 read completes normally.
- Back-to-back port 0 reads of 16'h0001 (=16'h1111) and 16'h0002 (=16'h2222) → rdata0 shows 16'h1111 then 16'h2222 on the successive done0 pulses, and rdata1 stays 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter.
//   state_e      : arbiter FSM states (IDLE / ACCESS / RESP)
//   PORT_CPU     : port 0, the multi-cycle CPU
//   PORT_LOAD    : port 1, the program/data loader or debug port
//   port_onehot  : maps a port id onto its bit of a 2-bit per-port vector
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_LOAD = 1'b1;

  function automatic logic [1:0] port_onehot(input logic port);
    return (port == PORT_LOAD) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Combinational two-way round-robin pick.
//   req_i        : per-port request
//   mask_i       : per-port exclusion (set for the port being served in RESP)
//   last_owner_i : port that won the previous grant
//   winner_o     : selected port id
//   valid_o      : at least one unmasked request exists
module rr_arbiter2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic [1:0] mask_i,
  input  logic       last_owner_i,
  output logic       winner_o,
  output logic       valid_o
);

  logic [1:0] eligible;

  assign eligible = req_i & ~mask_i;
  assign valid_o  = |eligible;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else can leave it unassigned and infer a latch.
  always_comb begin
    winner_o = PORT_CPU;
    if (eligible == 2'b11) begin
      // Contention: the port that did not go last wins.
      winner_o = ~last_owner_i;
    end else if (eligible[1]) begin
      winner_o = PORT_LOAD;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the CPU (port 0) and the
// loader/debug port (port 1). Each transaction takes one ACCESS cycle (RAM
// selected) and one RESP cycle (read data returned); the next grant can be
// issued in RESP, so continuous demand gives one transaction per two cycles.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   req_i, rnw_i             : per-port level request and direction (1 = read)
//   addr0_i/addr1_i          : per-port address
//   wdata0_i/wdata1_i        : per-port write data
//   grant_o                  : one-cycle pulse, port's inputs captured
//   done_o                   : one-cycle pulse, transaction complete
//   rdata0_o/rdata1_o        : per-port read data, held until next read done
//   mem_cs_o                 : RAM chip select (ACCESS only)
//   mem_read_not_write_o     : RAM direction, 1 outside ACCESS
//   mem_address_o            : RAM address (holds last value when idle)
//   mem_write_data_o         : RAM write data (holds last value when idle)
//   mem_read_data_i          : RAM read data, valid in the cycle after ACCESS
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 16,
  parameter int ADDR_WIDTH     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [1:0]                req_i,
  input  logic [1:0]                rnw_i,
  input  logic [ADDR_WIDTH-1:0]     addr0_i,
  input  logic [ADDR_WIDTH-1:0]     addr1_i,
  input  logic [DATA_BUS_WIDTH-1:0] wdata0_i,
  input  logic [DATA_BUS_WIDTH-1:0] wdata1_i,
  output logic [1:0]                grant_o,
  output logic [1:0]                done_o,
  output logic [DATA_BUS_WIDTH-1:0] rdata0_o,
  output logic [DATA_BUS_WIDTH-1:0] rdata1_o,
  output logic                      mem_cs_o,
  output logic                      mem_read_not_write_o,
  output logic [ADDR_WIDTH-1:0]     mem_address_o,
  output logic [DATA_BUS_WIDTH-1:0] mem_write_data_o,
  input  logic [DATA_BUS_WIDTH-1:0] mem_read_data_i
);

  state_e                    state_q, state_d;
  logic                      owner_q;
  logic                      last_owner_q;
  logic                      rnw_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_BUS_WIDTH-1:0] wdata_q;
  logic [1:0]                done_q, done_d;
  logic [DATA_BUS_WIDTH-1:0] rdata0_q, rdata1_q;

  logic [1:0] arb_mask;
  logic       arb_en;
  logic       arb_winner;
  logic       arb_valid;
  logic       take;

  // In RESP the current owner's request is still high (the port only drops
  // it once it sees done), so it is masked for this one cycle.
  assign arb_mask = (state_q == ST_RESP) ? port_onehot(owner_q) : 2'b00;
  assign arb_en   = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign take     = arb_en && arb_valid;

  rr_arbiter2 u_rr (
    .req_i        (req_i),
    .mask_i       (arb_mask),
    .last_owner_i (last_owner_q),
    .winner_o     (arb_winner),
    .valid_o      (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 2'b00;
    unique case (state_q)
      ST_IDLE:   if (arb_valid) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP: begin
        done_d  = port_onehot(owner_q);
        state_d = arb_valid ? ST_ACCESS : ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      done_q       <= 2'b00;
      owner_q      <= PORT_CPU;
      last_owner_q <= PORT_LOAD;  // port 0 wins the first tie
      rnw_q        <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (take) begin
        owner_q      <= arb_winner;
        last_owner_q <= arb_winner;
        rnw_q        <= (arb_winner == PORT_LOAD) ? rnw_i[1] : rnw_i[0];
        addr_q       <= (arb_winner == PORT_LOAD) ? addr1_i : addr0_i;
        wdata_q      <= (arb_winner == PORT_LOAD) ? wdata1_i : wdata0_i;
      end
      // Owner/rnw still describe the finishing transaction here even if a
      // new grant is captured on this same edge.
      if (state_q == ST_RESP && rnw_q) begin
        if (owner_q == PORT_LOAD) rdata1_q <= mem_read_data_i;
        else                      rdata0_q <= mem_read_data_i;
      end
    end
  end

  assign grant_o              = take ? port_onehot(arb_winner) : 2'b00;
  assign done_o               = done_q;
  assign rdata0_o             = rdata0_q;
  assign rdata1_o             = rdata1_q;
  assign mem_cs_o             = (state_q == ST_ACCESS);
  assign mem_read_not_write_o = (state_q != ST_ACCESS) || rnw_q;
  assign mem_address_o        = addr_q;
  assign mem_write_data_o     = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port RAM and a
// per-port scoreboard of expected completions.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req, rnw;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  grant_o, done_o;
  logic [15:0] rdata0_o, rdata1_o;
  logic        mem_cs_o, mem_read_not_write_o;
  logic [15:0] mem_address_o, mem_write_data_o;
  logic [15:0] mem_rd;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic        rd;
    logic [15:0] data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] ram     [0:255];
  logic [15:0] ref_mem [0:255];

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_BUS_WIDTH(16), .ADDR_WIDTH(16)) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .req_i                (req),
    .rnw_i                (rnw),
    .addr0_i              (addr0),
    .addr1_i              (addr1),
    .wdata0_i             (wdata0),
    .wdata1_i             (wdata1),
    .grant_o              (grant_o),
    .done_o               (done_o),
    .rdata0_o             (rdata0_o),
    .rdata1_o             (rdata1_o),
    .mem_cs_o             (mem_cs_o),
    .mem_read_not_write_o (mem_read_not_write_o),
    .mem_address_o        (mem_address_o),
    .mem_write_data_o     (mem_write_data_o),
    .mem_read_data_i      (mem_rd)
  );

  // Single-port synchronous RAM: write commits and read data registers on the
  // edge that ends the selected cycle.
  always @(posedge clk) begin
    if (mem_cs_o) begin
      if (!mem_read_not_write_o) ram[mem_address_o[7:0]] <= mem_write_data_o;
      mem_rd <= ram[mem_address_o[7:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests_run++;
    if (act !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  function automatic logic [1:0] onehot(input int p);
    return (p == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic push_exp(input int p, input logic rd, input logic [15:0] a, input logic [15:0] wd);
    exp_t e;
    e.rd   = rd;
    e.data = rd ? ref_mem[a[7:0]] : wd;
    if (!rd) ref_mem[a[7:0]] = wd;
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Monitor: every done pulse retires the oldest expected transaction of
  // that port; reads also compare the returned data.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done_o[0]) begin
        if (q0.size() == 0) begin
          tests_run++; tests_failed++;
          $display("FAIL done0_unexpected: got done_o=0x%0h, expected no pending port 0 done", done_o);
        end else begin
          e = q0.pop_front();
          if (e.rd) check("rdata0", rdata0_o, e.data);
          else      check("done0_write_onehot", done_o, 2'b01);
        end
      end
      if (done_o[1]) begin
        if (q1.size() == 0) begin
          tests_run++; tests_failed++;
          $display("FAIL done1_unexpected: got done_o=0x%0h, expected no pending port 1 done", done_o);
        end else begin
          e = q1.pop_front();
          if (e.rd) check("rdata1", rdata1_o, e.data);
          else      check("done1_write_onehot", done_o, 2'b10);
        end
      end
    end
  end

  // Single transaction from an idle arbiter with cycle-accurate checks:
  // grant at T, ACCESS at T+1, RESP at T+2, done at T+3.
  task automatic txn_timed(input int p, input logic rd, input logic [15:0] a, input logic [15:0] wd);
    req[p] = 1'b1;
    rnw[p] = rd;
    if (p == 0) begin addr0 = a; wdata0 = wd; end
    else        begin addr1 = a; wdata1 = wd; end
    @(negedge clk);
    check("t_grant", grant_o, onehot(p));
    push_exp(p, rd, a, wd);
    @(posedge clk); #1;
    req[p] = 1'b0;
    @(negedge clk);
    check("t_access_cs", mem_cs_o, 1);
    check("t_access_rnw", mem_read_not_write_o, rd);
    check("t_access_addr", mem_address_o, a);
    if (!rd) check("t_access_wdata", mem_write_data_o, wd);
    @(negedge clk);
    check("t_resp_cs", mem_cs_o, 0);
    check("t_resp_rnw", mem_read_not_write_o, 1);
    @(negedge clk);
    check("t_done", done_o, onehot(p));
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, grant_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_rdata0"}, rdata0_o, 0);
    check({tag, "_rdata1"}, rdata1_o, 0);
    check({tag, "_cs"}, mem_cs_o, 0);
    check({tag, "_rnw"}, mem_read_not_write_o, 1);
    check({tag, "_addr"}, mem_address_o, 0);
    check({tag, "_wdata"}, mem_write_data_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int gcount, cs_cnt, d0, d1, g1, dn, dc;

    for (int i = 0; i < 256; i++) begin
      ram[i]     = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    ram[1] = 16'h1111; ref_mem[1] = 16'h1111;
    ram[2] = 16'h2222; ref_mem[2] = 16'h2222;
    mem_rd = 16'h0000;
    req = 2'b00; rnw = 2'b11;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // Reset values.
    #3;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Simultaneous reads after reset: port 0 first, port 1 granted in RESP.
    req = 2'b11; rnw = 2'b11; addr0 = 16'h0001; addr1 = 16'h0002;
    @(negedge clk);
    check("sim_grant_first", grant_o, 2'b01);
    push_exp(0, 1'b1, 16'h0001, 16'h0000);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    check("sim_access_nogrant", grant_o, 2'b00);
    check("sim_access_cs", mem_cs_o, 1);
    @(negedge clk);
    check("sim_resp_grant", grant_o, 2'b10);
    push_exp(1, 1'b1, 16'h0002, 16'h0000);
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(negedge clk);
    check("sim_done0", done_o, 2'b01);
    check("sim_no_idle_gap", mem_cs_o, 1);
    @(negedge clk);
    check("sim_gap_cycle", done_o, 2'b00);
    @(negedge clk);
    check("sim_done1", done_o, 2'b10);
    @(posedge clk); #1;

    // Continuous demand on both ports for 8 grants.
    gcount = 0; cs_cnt = 0; d0 = 0; d1 = 0;
    req = 2'b11; rnw = 2'b11; addr0 = 16'h0001; addr1 = 16'h0002;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (grant_o != 2'b00) begin
        check("cont_grant_port", grant_o, onehot(gcount % 2));
        check("cont_grant_cycle", c, 2 * gcount);
        push_exp(gcount % 2, 1'b1, (gcount % 2 == 1) ? 16'h0002 : 16'h0001, 16'h0000);
        gcount++;
      end
      cs_cnt += int'(mem_cs_o);
      d0 += int'(done_o[0]);
      d1 += int'(done_o[1]);
      @(posedge clk); #1;
      if (gcount >= 8) req = 2'b00;
    end
    req = 2'b00;
    check("cont_grants", gcount, 8);
    check("cont_cs_cycles", cs_cnt, 8);
    check("cont_done0", d0, 4);
    check("cont_done1", d1, 4);

    // Port 1 holds req one cycle past done: exactly one extra transaction.
    g1 = 0; dn = 0; dc = -1;
    req[1] = 1'b1; rnw[1] = 1'b1; addr1 = 16'h0002;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (grant_o[1]) begin
        g1++;
        push_exp(1, 1'b1, 16'h0002, 16'h0000);
      end
      if (done_o[1]) begin
        dn++;
        if (dc < 0) dc = c;
      end
      @(posedge clk); #1;
      if (dc >= 0 && c == dc + 1) req[1] = 1'b0;
    end
    req = 2'b00;
    check("hold_grants", g1, 2);
    check("hold_dones", dn, 2);
    check("hold_rdata0_kept", rdata0_o, 16'h1111);

    // Port 0 write then read of the same word.
    txn_timed(0, 1'b0, 16'h0010, 16'hBEEF);
    txn_timed(0, 1'b1, 16'h0010, 16'h0000);
    check("wr_rd_rdata0", rdata0_o, 16'hBEEF);

    // Reset during ACCESS of a port 1 write.
    req[1] = 1'b1; rnw[1] = 1'b0; addr1 = 16'h0030; wdata1 = 16'h5555;
    @(negedge clk);
    check("rst_mid_grant", grant_o, 2'b10);
    @(posedge clk); #1;
    req[1] = 1'b0;
    check("rst_mid_pre_cs", mem_cs_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    dn = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      dn += int'(done_o[1]);
    end
    check("rst_mid_no_done1", dn, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn_timed(0, 1'b1, 16'h0010, 16'h0000);
    check("post_rst_rdata0", rdata0_o, 16'hBEEF);

    // Back-to-back port 0 reads; port 1 data stays at reset value.
    txn_timed(0, 1'b1, 16'h0001, 16'h0000);
    check("b2b_first", rdata0_o, 16'h1111);
    txn_timed(0, 1'b1, 16'h0002, 16'h0000);
    check("b2b_second", rdata0_o, 16'h2222);
    check("b2b_rdata1_zero", rdata1_o, 16'h0000);

    repeat (3) @(posedge clk);
    check("pending_port0", q0.size(), 0);
    check("pending_port1", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
